// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states and default sizes.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a bit into the partial remainder,
// trial-subtract the divisor magnitude, keep the difference if it fits.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH:0]   dmag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sel;
  logic           unused_sel_msb;

  // Trial subtraction and restore mux.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= dmag);
    diff    = shifted - dmag;
    sel     = q_bit ? diff : shifted;
    // The kept remainder is always below dmag <= 2^(WIDTH-1), so the top bit is zero.
    rem_out        = sel[WIDTH-1:0];
    unused_sel_msb = sel[WIDTH];
  end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// truncating quotient, remainder signed like the dividend, ovf/dz flags.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// captures dividend/divisor. busy is high while computing. done pulses for one
// cycle when results are valid; results hold until the next operation ends.
// start seen at any other time is dropped, never queued.
module signed_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [2*WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0]   divisor,
  output logic                      busy,
  output logic                      done,
  output logic signed [WIDTH-1:0]   quotient,
  output logic signed [WIDTH-1:0]   remainder,
  output logic                      ovf,
  output logic                      dz,
  output logic [1:0]                dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] NEG_LIM = (WIDTH+1)'(1) << (WIDTH - 1);

  div_state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               q_neg;
  logic               r_neg;
  logic               dz_f;
  logic               povf_f;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     dmag;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]     dvs_ext;
  logic [WIDTH:0]     dvs_mag;
  logic               dvs_zero;
  logic               pre_ovf;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               range_bad;

  // Operand magnitudes and early-exit decisions for the accepting edge.
  always_comb begin
    dvd_mag  = dividend[2*WIDTH-1] ? -dividend : dividend;
    dvs_ext  = {divisor[WIDTH-1], divisor};
    dvs_mag  = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
    dvs_zero = (divisor == '0);
    pre_ovf  = ({1'b0, dvd_mag[2*WIDTH-1:WIDTH]} >= dvs_mag);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (lo[WIDTH-1]),
    .dmag    (dmag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Quotient magnitude that cannot be represented once the sign is applied.
  always_comb begin
    range_bad = q_neg ? ({1'b0, lo} > NEG_LIM) : lo[WIDTH-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    dbg_state = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (dvs_zero || pre_ovf) ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, restoring iterations, sign fix-up and result registers.
  // done is registered off the DONE state so it is visible the cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz_f      <= 1'b0;
      povf_f    <= 1'b0;
      rem       <= '0;
      lo        <= '0;
      dmag      <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q_neg  <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            r_neg  <= dividend[2*WIDTH-1];
            rem    <= dvd_mag[2*WIDTH-1:WIDTH];
            lo     <= dvd_mag[WIDTH-1:0];
            dmag   <= dvs_mag;
            cnt    <= CW'(WIDTH);
            dz_f   <= dvs_zero;
            povf_f <= !dvs_zero && pre_ovf;
          end
        end
        CALC: begin
          rem <= step_rem;
          lo  <= {lo[WIDTH-2:0], step_q};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (dz_f) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b1;
          end else if (povf_f || range_bad) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b1;
            dz        <= 1'b0;
          end else begin
            quotient  <= q_neg ? -lo : lo;
            remainder <= r_neg ? -rem : rem;
            ovf       <= 1'b0;
            dz        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider (WIDTH=32).
module tb_signed_divider;

  localparam int W = 32;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic signed [2*W-1:0] dividend;
  logic signed [W-1:0]   divisor;
  logic                  busy;
  logic                  done;
  logic signed [W-1:0]   quotient;
  logic signed [W-1:0]   remainder;
  logic                  ovf;
  logic                  dz;
  logic [1:0]            dbg_state;

  int checks;
  int errors;

  signed_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation; report edges from the accepting edge to done and busy cycles.
  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat      = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_res(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic eo, input logic ez);
    checks++;
    if (quotient !== eq || remainder !== er || ovf !== eo || dz !== ez) begin
      errors++;
      $display("FAIL %s: got q=%h r=%h ovf=%b dz=%b, want q=%h r=%h ovf=%b dz=%b",
               name, quotient, remainder, ovf, dz, eq, er, eo, ez);
    end
  endtask

  task automatic check_lat(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ovf, dz} !== 4'b0000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
               busy, done, quotient, remainder, ovf, dz);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_positive();
    int lat, bc;
    run_op(64'sd100, 32'sd7, lat, bc);
    check_res("pos_100_7", 32'd14, 32'd2, 1'b0, 1'b0);
    check_lat("pos_latency", lat, 34);
    check_lat("pos_busy_cycles", bc, 33);
  endtask

  task automatic test_signs();
    int lat, bc;
    run_op(-64'sd100, 32'sd7, lat, bc);
    check_res("neg_dvd", -32'sd14, -32'sd2, 1'b0, 1'b0);
    run_op(64'sd100, -32'sd7, lat, bc);
    check_res("neg_dvs", -32'sd14, 32'sd2, 1'b0, 1'b0);
    run_op(-64'sd100, -32'sd7, lat, bc);
    check_res("neg_both", 32'sd14, -32'sd2, 1'b0, 1'b0);
  endtask

  task automatic test_round_trip();
    int lat, bc;
    run_op(64'h3FFFFFFF00000001, 32'h7FFFFFFF, lat, bc);
    check_res("rt_max_pos", 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0);
    run_op(64'h4000000000000000, 32'h80000000, lat, bc);
    check_res("rt_min_neg", 32'h80000000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_op(64'h0000000080000000, 32'd1, lat, bc);
    check_res("ovf_range", 32'h0, 32'h0, 1'b1, 1'b0);
    check_lat("ovf_range_latency", lat, 34);
    run_op(64'h0000000100000000, 32'd1, lat, bc);
    check_res("ovf_early", 32'h0, 32'h0, 1'b1, 1'b0);
    check_lat("ovf_early_latency", lat, 2);
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(64'sd12345, 32'd0, lat, bc);
    check_res("dz", 32'h0, 32'h0, 1'b0, 1'b1);
    check_lat("dz_latency", lat, 2);
    check_lat("dz_busy_cycles", bc, 1);
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    dividend = 64'sd100; divisor = 32'sd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      // Stray requests with other operands while computing.
      if (k == 5 || k == 6 || k == 20) begin
        dividend = 64'sd50; divisor = 32'sd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check_res("ignored_start", 32'd14, 32'd2, 1'b0, 1'b0);
    check_lat("ignored_latency", lat, 34);
    repeat (4) @(posedge clk);
    #1;
    check_res("hold_after_done", 32'd14, 32'd2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    dividend = 64'sd100; divisor = 32'sd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, dz} !== 4'b0000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
               busy, done, quotient, remainder, ovf, dz);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check_lat("no_done_after_reset", seen, 0);
  endtask

  task automatic test_fresh();
    int lat, bc;
    run_op(64'sd50, 32'sd5, lat, bc);
    check_res("fresh_50_5", 32'd10, 32'd0, 1'b0, 1'b0);
    check_lat("fresh_latency", lat, 34);
  endtask

  task automatic test_back_to_back();
    int first, second;
    @(negedge clk);
    dividend = 64'sd1000; divisor = 32'sd3; start = 1'b1;
    first = -1; second = -1;
    for (int k = 0; k <= 120; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          break;
        end
      end
    end
    start = 1'b0;
    check_res("b2b_result", 32'd333, 32'd1, 1'b0, 1'b0);
    check_lat("b2b_first", first, 34);
    check_lat("b2b_gap", second - first, 35);
    repeat (40) @(posedge clk);
  endtask

  // Sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_positive();
    test_signs();
    test_round_trip();
    test_overflow();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_fresh();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
# signed_divider

Multi-cycle signed divider that inverts the multiplier datapath. It divides a 2·WIDTH-bit signed dividend by a WIDTH-bit signed divisor and returns a WIDTH-bit quotient and remainder. Truncating (round-toward-zero) semantics apply, and overflow and divide-by-zero are flagged. It sits beside the multiplier in the arithmetic unit so that a product Z can be divided back by either operand, recovering the other operand with remainder 0.

## Interface
- WIDTH, 32, operand width; dividend is 2·WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  signed [2·WIDTH-1:0]  captured on the accepting edge.
- divisor  in  signed [WIDTH-1:0]  captured on the accepting edge.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; results are valid while it is high and held afterward.
- quotient  out  signed [WIDTH-1:0]  truncated quotient.
- remainder  out  signed [WIDTH-1:0]  remainder, with the same sign as the dividend (or zero).
- ovf  out  1  quotient not representable in WIDTH signed bits.
- dz  out  1  divisor was zero.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE → accept:** when start=1, the edge captures the sign of each operand and the absolute magnitude of each (dividend in 2·WIDTH bits, divisor in WIDTH+1 bits). It also sets the iteration count to WIDTH.
- **Early exit:**
  - If divisor == 0, set dz and go IDLE→FIX.
  - Otherwise, if magnitude upper half ≥ |divisor| (magnitude quotient ≥ 2^WIDTH), set pre-overflow and go IDLE→FIX.
  - Otherwise go IDLE→CALC.
- **CALC:** one restoring-division step per edge.
  - Shift the {partial remainder, dividend low} pair left by one bit.
  - Trial-subtract |divisor| using WIDTH+1-bit arithmetic.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - After WIDTH steps, go to FIX.
- **FIX:**
  - Negate the quotient magnitude if the signs differ.
  - Negate the remainder magnitude if the dividend is negative.
  - Set ovf if pre-overflow is set, or if the positive result is > 2^(WIDTH-1)-1, or if the negative result is > 2^(WIDTH-1) in magnitude.
  - If ovf or dz is set, quotient and remainder are forced to 0.
  - Register all outputs and go to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE.
- **Output hold:** quotient, remainder, ovf and dz hold until the next FIX completes. They are not cleared when start is accepted.
- **start outside IDLE:** ignored (no queuing), including start asserted in DONE.
- **Level-held start:** start held high re-triggers in IDLE, the cycle after DONE.
- **Reset:** rst low at any time, including mid-CALC, immediately forces IDLE.
  - busy=0, done=0, quotient=0, remainder=0, ovf=0, dz=0, internal registers 0.
  - Operation resumes only on a start that follows reset release.

## Timing
- Edge E0 accepts start.
- **Normal path:**
  - busy is high after E0 through E_{WIDTH+1}.
  - Outputs and done become visible after edge E_{WIDTH+2}. For WIDTH=32 that is E34, i.e. 34 edges of latency.
- **Early exit (dz or pre-overflow):**
  - FIX occupies the cycle after E0.
  - done is visible after E2.
- **Throughput:** the next start can be accepted at the edge after done falls (IDLE).
- There is no combinational path from inputs to outputs.

## Structure
- **Package `arith_pkg`:**
  - state enum {IDLE, CALC, FIX, DONE}.
  - DIV_WIDTH default constant (32).
  - iteration-counter width, $clog2(WIDTH+1).
- **Sub-module `div_step`:** purely combinational, one restoring step.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Instantiated once and used every CALC cycle.

## Test plan
- **Positive operands:** dividend=100, divisor=7 → quotient=14, remainder=2, ovf=0, dz=0. done is high exactly 34 edges after the accepting edge and busy stays high for 33 cycles.
- **Signs:**
  - -100/7 → quotient=-14, remainder=-2.
  - 100/-7 → quotient=-14, remainder=2.
  - -100/-7 → quotient=14, remainder=-2.
- **Round trip:**
  - 0x3FFFFFFF00000001 / 0x7FFFFFFF → quotient=0x7FFFFFFF, remainder=0.
  - 0x4000000000000000 / 0x80000000 → quotient=0x80000000, remainder=0, ovf=0.
- **Overflow:**
  - 0x0000000080000000 / 1 → ovf=1, quotient=0, remainder=0, after 34 edges (post-fix range check).
  - 0x0000000100000000 / 1 → ovf=1 via early exit, done after E2.
- **Divide by zero:** any dividend / 0 → dz=1, ovf=0, quotient=0, remainder=0, done after E2.
- **Control:**
  - Start pulses during CALC are ignored; the result matches the first operands.
  - Asserting rst low at cycle 10 of CALC clears all outputs immediately and no done follows.
  - A fresh start after reset (e.g. 50/5) → quotient=10, remainder=0.
